// File: rtl/bp_pkg.sv
// Shared constants and helpers for the branch predictor: direction-counter
// encodings and the saturating next-count function.
package bp_pkg;

  function automatic int unsigned cnt_weak_nt(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned cnt_weak_t(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned cnt_min(input int unsigned w);
    return (w == 0) ? 32'd0 : 32'd0;
  endfunction

  // Increment or decrement by one, holding at the bounds; inc and dec
  // together (or neither) leave the count unchanged.
  function automatic logic [31:0] sat_next(input logic [31:0] cur,
                                           input logic [31:0] max,
                                           input logic        inc,
                                           input logic        dec);
    logic [31:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != max)) begin
      nxt = cur + 32'd1;
    end else if (dec && !inc && (cur != 32'd0)) begin
      nxt = cur - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-state logic for a W-bit saturating up/down counter (W <= 32).
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [31:0] MAX = cnt_max(W);

  assign cnt_o = W'(sat_next(32'(cnt_i), MAX, inc_i, dec_i));

endmodule

// File: rtl/bp_btb_2bit.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters,
// registered one-cycle prediction, synchronous flush and saturating stats.
module bp_btb_2bit
  import bp_pkg::*;
#(
  parameter int unsigned PC_W   = 12,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispredict,
  input  logic              flush,
  output logic [STAT_W-1:0] update_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int unsigned TAG_W = PC_W - IDX_W;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(cnt_weak_t(CNT_W));

  logic              valid_q [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [PC_W-1:0]   tgt_q   [DEPTH];
  logic [CNT_W-1:0]  cnt_q   [DEPTH];

  logic              pred_valid_q, pred_hit_q, pred_taken_q;
  logic [PC_W-1:0]   pred_target_q;
  logic [STAT_W-1:0] upd_cnt_q, mis_cnt_q, upd_cnt_d, mis_cnt_d;

  logic [IDX_W-1:0]  u_idx, l_idx;
  logic [TAG_W-1:0]  u_tag, l_tag;
  logic              u_hit, upd_we;
  logic [CNT_W-1:0]  cnt_step, new_cnt;
  logic [PC_W-1:0]   new_tgt;

  assign u_idx = upd_pc[IDX_W-1:0];
  assign u_tag = upd_pc[PC_W-1:IDX_W];
  assign l_idx = lookup_pc[IDX_W-1:0];
  assign l_tag = lookup_pc[PC_W-1:IDX_W];

  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  // A miss only allocates on a taken branch; flush drops the array write.
  assign upd_we = upd_valid && !flush && (u_hit || upd_taken);

  bp_sat_counter #(.W(CNT_W)) u_dir_cnt (
    .cnt_i (cnt_q[u_idx]),
    .inc_i (upd_taken),
    .dec_i (!upd_taken),
    .cnt_o (cnt_step)
  );

  assign new_cnt = u_hit ? cnt_step : CNT_ALLOC;
  assign new_tgt = upd_taken ? upd_target : tgt_q[u_idx];

  // Lookup sees the entry as it will be after this cycle's update.
  logic             fwd, e_valid, l_hit, l_taken;
  logic [TAG_W-1:0] e_tag;
  logic [PC_W-1:0]  e_tgt, l_target;
  logic [CNT_W-1:0] e_cnt;

  always_comb begin
    fwd      = upd_we && (u_idx == l_idx);
    e_valid  = fwd ? 1'b1    : valid_q[l_idx];
    e_tag    = fwd ? u_tag   : tag_q[l_idx];
    e_tgt    = fwd ? new_tgt : tgt_q[l_idx];
    e_cnt    = fwd ? new_cnt : cnt_q[l_idx];
    l_hit    = !flush && e_valid && (e_tag == l_tag);
    l_taken  = l_hit && e_cnt[CNT_W-1];
    l_target = l_taken ? e_tgt : lookup_pc + PC_W'(1);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= CNT_INIT;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_we) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      tgt_q[u_idx]   <= new_tgt;
      cnt_q[u_idx]   <= new_cnt;
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pred_valid_q  <= 1'b0;
      pred_hit_q    <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      pred_valid_q  <= lookup_valid;
      pred_hit_q    <= lookup_valid && l_hit;
      pred_taken_q  <= lookup_valid && l_taken;
      pred_target_q <= lookup_valid ? l_target : '0;
    end
  end

  bp_sat_counter #(.W(STAT_W)) u_upd_stat (
    .cnt_i (upd_cnt_q),
    .inc_i (upd_valid),
    .dec_i (1'b0),
    .cnt_o (upd_cnt_d)
  );

  bp_sat_counter #(.W(STAT_W)) u_mis_stat (
    .cnt_i (mis_cnt_q),
    .inc_i (upd_valid && upd_mispredict),
    .dec_i (1'b0),
    .cnt_o (mis_cnt_d)
  );

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_hit         = pred_hit_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign update_count     = upd_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule
